// File: rtl/openram_march_bist.sv
// March C- self test for OpenRAM port 0. When idle the bridge passes straight through to the macro.
// When running, the BIST owns the port and reports pass/fail with the first failing address and element.
module openram_march_bist #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      bist_start_i,
  output logic                      bist_busy_o,
  output logic                      bist_done_o,
  output logic                      bist_pass_o,
  output logic [ADDR_WIDTH-1:0]     bist_fail_addr_o,
  output logic [2:0]                bist_fail_elem_o,
  output logic                      up_stall_o,
  input  logic                      up_csb0,
  input  logic                      up_web0,
  input  logic [DATA_WIDTH/8-1:0]   up_wmask0,
  input  logic [ADDR_WIDTH-1:0]     up_addr0,
  input  logic [DATA_WIDTH-1:0]     up_din0,
  output logic [DATA_WIDTH-1:0]     up_dout0,
  output logic                      ram_csb0,
  output logic                      ram_web0,
  output logic [DATA_WIDTH/8-1:0]   ram_wmask0,
  output logic [ADDR_WIDTH-1:0]     ram_addr0,
  output logic [DATA_WIDTH-1:0]     ram_din0,
  input  logic [DATA_WIDTH-1:0]     ram_dout0
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  logic [1:0]            state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_ph_q, wr_ph_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_exp_q, rd_exp_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]            rd_elem_q, rd_elem_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]            fail_elem_q, fail_elem_d;

  logic busy, down, is_read, is_write, rd_val, wr_val, mismatch, last_addr, step;

  always_comb begin
    busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    down      = (elem_q >= 3'd3);
    // E0 is write-only, E5 read-only; E1..E4 alternate R then W at each address
    is_read   = (state_q == S_RUN) && ((elem_q == 3'd5) || ((elem_q != 3'd0) && !wr_ph_q));
    is_write  = (state_q == S_RUN) && !is_read;
    rd_val    = (elem_q == 3'd2) || (elem_q == 3'd4);
    wr_val    = (elem_q == 3'd1) || (elem_q == 3'd3);
    mismatch  = rd_pend_q && (ram_dout0 != {DATA_WIDTH{rd_exp_q}});
    last_addr = down ? (addr_q == '0) : (addr_q == ADDR_LAST);
    step      = (elem_q == 3'd0) || (elem_q == 3'd5) || wr_ph_q;

    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    wr_ph_d     = wr_ph_q;
    rd_pend_d   = 1'b0;
    rd_exp_d    = rd_exp_q;
    rd_addr_d   = rd_addr_q;
    rd_elem_d   = rd_elem_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bist_start_i) begin
          state_d     = S_RUN;
          elem_d      = 3'd0;
          addr_d      = '0;
          wr_ph_d     = 1'b0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = 3'd0;
        end
      end
      S_RUN: begin
        rd_pend_d = is_read;
        rd_exp_d  = rd_val;
        rd_addr_d = addr_q;
        rd_elem_d = elem_q;
        if (mismatch) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          pass_d      = 1'b0;
          fail_addr_d = rd_addr_q;
          fail_elem_d = rd_elem_q;
          rd_pend_d   = 1'b0;
        end else begin
          wr_ph_d = ((elem_q != 3'd0) && (elem_q != 3'd5)) ? !wr_ph_q : 1'b0;
          if (step) begin
            if (last_addr) begin
              if (elem_q == 3'd5) begin
                state_d = S_DRAIN;
              end else begin
                elem_d  = elem_q + 3'd1;
                addr_d  = (elem_q >= 3'd2) ? ADDR_LAST : '0;
                wr_ph_d = 1'b0;
              end
            end else begin
              addr_d = down ? (addr_q - 1'b1) : (addr_q + 1'b1);
            end
          end
        end
      end
      default: begin
        // DRAIN: last E5 read data arrives now
        state_d = S_DONE;
        done_d  = 1'b1;
        if (mismatch) begin
          pass_d      = 1'b0;
          fail_addr_d = rd_addr_q;
          fail_elem_d = rd_elem_q;
        end else begin
          pass_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      wr_ph_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_exp_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_elem_q   <= 3'd0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      wr_ph_q     <= wr_ph_d;
      rd_pend_q   <= rd_pend_d;
      rd_exp_q    <= rd_exp_d;
      rd_addr_q   <= rd_addr_d;
      rd_elem_q   <= rd_elem_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  always_comb begin
    bist_busy_o      = busy;
    bist_done_o      = done_q;
    bist_pass_o      = pass_q;
    bist_fail_addr_o = fail_addr_q;
    bist_fail_elem_o = fail_elem_q;
    up_stall_o       = busy;
    ram_csb0         = busy ? (state_q == S_DRAIN) : up_csb0;
    ram_web0         = busy ? !is_write : up_web0;
    ram_wmask0       = busy ? '1 : up_wmask0;
    ram_addr0        = busy ? addr_q : up_addr0;
    ram_din0         = busy ? {DATA_WIDTH{wr_val}} : up_din0;
    up_dout0         = busy ? '0 : ram_dout0;
  end

endmodule

// File: tb/tb_openram_march_bist.sv
// Bench for openram_march_bist: behavioural SRAM with injectable stuck-at cell, march-level reference model,
// and a queue scoreboard checked by a monitor whenever a run completes.
module tb_openram_march_bist;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, pass, stall;
  logic [7:0]  fail_addr;
  logic [2:0]  fail_elem;
  logic        up_csb0, up_web0;
  logic [3:0]  up_wmask0;
  logic [7:0]  up_addr0;
  logic [31:0] up_din0, up_dout0;
  logic        ram_csb0, ram_web0;
  logic [3:0]  ram_wmask0;
  logic [7:0]  ram_addr0;
  logic [31:0] ram_din0, ram_dout0;

  always #5 clk = ~clk;

  openram_march_bist dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .bist_start_i(start),
    .bist_busy_o(busy), .bist_done_o(done), .bist_pass_o(pass),
    .bist_fail_addr_o(fail_addr), .bist_fail_elem_o(fail_elem), .up_stall_o(stall),
    .up_csb0(up_csb0), .up_web0(up_web0), .up_wmask0(up_wmask0), .up_addr0(up_addr0),
    .up_din0(up_din0), .up_dout0(up_dout0),
    .ram_csb0(ram_csb0), .ram_web0(ram_web0), .ram_wmask0(ram_wmask0), .ram_addr0(ram_addr0),
    .ram_din0(ram_din0), .ram_dout0(ram_dout0)
  );

  // fault: 0 none, 1 stuck-at-0, 2 stuck-at-1
  int          f_kind = 0;
  int          f_addr = 0;
  int          f_bit  = 0;
  int          n_vec  = 0;
  int          n_err  = 0;

  function automatic logic [31:0] faulty(logic [31:0] d, int a);
    if (f_kind == 1 && a == f_addr) d[f_bit] = 1'b0;
    if (f_kind == 2 && a == f_addr) d[f_bit] = 1'b1;
    return d;
  endfunction

  logic [31:0] mem [256];
  logic [31:0] w;
  always @(posedge clk) begin
    if (!ram_csb0) begin
      if (!ram_web0) begin
        w = mem[ram_addr0];
        for (int b = 0; b < 4; b++) if (ram_wmask0[b]) w[b*8 +: 8] = ram_din0[b*8 +: 8];
        mem[ram_addr0] <= faulty(w, int'(ram_addr0));
      end else begin
        ram_dout0 <= mem[ram_addr0];
      end
    end
  end

  typedef struct {
    int pass;
    int addr;
    int elem;
    int busy;
  } exp_t;
  exp_t sb_q[$];

  // Walks the March C- sequence as a list of operations over an abstract memory.
  function automatic exp_t march_model();
    logic [31:0] m [256];
    logic [31:0] ev;
    exp_t r;
    int k, a;
    r.pass = 1; r.addr = 0; r.elem = 0; r.busy = 2561;
    k = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 256; i++) begin
        a = (e < 3) ? i : 255 - i;
        if (e > 0) begin
          ev = (e == 2 || e == 4) ? 32'hFFFF_FFFF : 32'h0;
          if (m[a] !== ev) begin
            r.pass = 0; r.addr = a; r.elem = e; r.busy = k + 2;
            return r;
          end
          k++;
        end
        if (e < 5) begin
          m[a] = faulty((e == 1 || e == 3) ? 32'hFFFF_FFFF : 32'h0, a);
          k++;
        end
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and checks results on each rising done.
  int   busy_cnt  = 0;
  logic prev_done = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) busy_cnt = 0;
      else if (busy) busy_cnt++;
      if (done && !prev_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("pass", 64'(pass), 64'(e.pass));
          check("fail_addr", 64'(fail_addr), 64'(e.addr));
          check("fail_elem", 64'(fail_elem), 64'(e.elem));
          check("busy_cycles", 64'(busy_cnt), 64'(e.busy));
          $display("run: kind=%0d addr=%0h bit=%0d -> pass=%0d fail_addr=%0h fail_elem=%0d busy=%0d",
                   f_kind, f_addr, f_bit, pass, fail_addr, fail_elem, busy_cnt);
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_march(input int kind, input int fa, input int fb, input bit poke);
    f_kind = kind; f_addr = fa; f_bit = fb;
    sb_q.push_back(march_model());
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_cleared_on_start", 64'(done), 64'd0);
    for (int c = 0; c < 4000 && !done; c++) begin
      tick();
      if (poke && c == 100) begin
        up_csb0 = 1'b0; up_web0 = 1'b0; up_wmask0 = 4'h3;
        up_addr0 = 8'($urandom); up_din0 = $urandom;
        @(negedge clk);
        check("stall_busy", 64'(stall), 64'd1);
        check("dout_zero_busy", 64'(up_dout0), 64'd0);
        check("wmask_busy", 64'(ram_wmask0), 64'hF);
        check("csb_busy", 64'(ram_csb0), 64'd0);
      end
      if (poke && c == 101) up_csb0 = 1'b1;
      if (poke && c == 500) start = 1'b1;
      if (poke && c == 501) start = 1'b0;
    end
    if (!done) check("done_timeout", 0, 1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    up_csb0 = 1'b1; up_web0 = 1'b1; up_wmask0 = 4'h0; up_addr0 = 8'h0; up_din0 = 32'h0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_fail_addr", 64'(fail_addr), 64'd0);
    check("rst_fail_elem", 64'(fail_elem), 64'd0);
    tick();
    rst = 1'b0;

    // Idle passthrough write then read
    up_csb0 = 1'b0; up_web0 = 1'b0; up_wmask0 = 4'hF; up_addr0 = 8'h10; up_din0 = 32'hDEADBEEF;
    @(negedge clk);
    check("pt_csb", 64'(ram_csb0), 64'd0);
    check("pt_web", 64'(ram_web0), 64'd0);
    check("pt_mask", 64'(ram_wmask0), 64'hF);
    check("pt_addr", 64'(ram_addr0), 64'h10);
    check("pt_din", 64'(ram_din0), 64'hDEADBEEF);
    tick();
    up_web0 = 1'b1;
    @(negedge clk);
    check("pt_web_rd", 64'(ram_web0), 64'd1);
    tick();
    up_csb0 = 1'b1;
    @(negedge clk);
    check("pt_dout", 64'(up_dout0), 64'hDEADBEEF);
    tick();

    run_march(0, 0, 0, 1'b1);
    run_march(1, 8'h3C, 5, 1'b0);
    for (int i = 0; i < 4; i++)
      run_march(int'($urandom_range(0, 2)), int'($urandom_range(0, 255)), int'($urandom_range(0, 31)), 1'b0);

    // Reset in the middle of E3, then a clean run
    f_kind = 0;
    sb_q.push_back(march_model());
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (1500) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_mux", 64'(ram_csb0), 64'(up_csb0));
    tick();
    run_march(0, 0, 0, 1'b0);

    repeat (3) tick();
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
